control_fsm: RTL

- Parametrised successor of the accumulator CPU's control sequencer: an explicit state machine driving the same datapath strobes (MUX, ALU, AR/PC/AC/ZC/IR/DR/temp-address loads).
- Generalises the operand address to ADDR_BYTES bytes.
- Adds a memory ready handshake (wait states), carry-conditional jumps, HLT, and illegal-opcode detection.
- Sits between the instruction register / ALU flags and the datapath register enables.

---
 rtl/control_fsm_if.sv | 46 ++++
 rtl/control_fsm.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_fsm_if.sv
// control_fsm_if: bundles the control sequencer's decode inputs and datapath
// strobes.
//   master : the sequencer side. It receives Instruction, flag_z, flag_c and
//            mem_ready, and drives MUX_sel, ALU_op, mem_req, memory_WE, the
//            register strobes, TMP_load, AB_sel, halted, illegal and dev_state.
//   slave  : the datapath/memory side, with the opposite directions.
interface control_fsm_if #(
  parameter int ADDR_BYTES = 2,
  parameter int OPC_W      = 8
);
  logic [OPC_W-1:0]      Instruction;
  logic                  flag_z;
  logic                  flag_c;
  logic                  mem_ready;
  logic [1:0]            MUX_sel;
  logic [3:0]            ALU_op;
  logic                  mem_req;
  logic                  memory_WE;
  logic                  AR_load;
  logic                  AR_inc;
  logic                  PC_load;
  logic                  PC_inc;
  logic                  AC_load;
  logic                  ZC_load;
  logic                  IR_load;
  logic                  DR_load;
  logic [ADDR_BYTES-1:0] TMP_load;
  logic                  AB_sel;
  logic                  halted;
  logic                  illegal;
  logic [3:0]            dev_state;

  modport master (
    input  Instruction, flag_z, flag_c, mem_ready,
    output MUX_sel, ALU_op, mem_req, memory_WE, AR_load, AR_inc, PC_load,
           PC_inc, AC_load, ZC_load, IR_load, DR_load, TMP_load, AB_sel,
           halted, illegal, dev_state
  );

  modport slave (
    output Instruction, flag_z, flag_c, mem_ready,
    input  MUX_sel, ALU_op, mem_req, memory_WE, AR_load, AR_inc, PC_load,
           PC_inc, AC_load, ZC_load, IR_load, DR_load, TMP_load, AB_sel,
           halted, illegal, dev_state
  );
endinterface

// File: rtl/control_fsm.sv
// control_fsm: control sequencer for the accumulator CPU. It fetches an
// opcode, decodes it, and then fetches an immediate byte or ADDR_BYTES
// operand address bytes (MSB first). After that it runs a jump or a
// load/store. Every memory transfer waits on mem_ready.
// Ports:
//   clk : rising-edge clock.
//   rst : asynchronous active-low reset.
//   bus : control_fsm_if.master. It carries the opcode, the flags and
//         mem_ready in, and the datapath strobes, halted, illegal and
//         dev_state out.
// Outputs are combinational from the state, the byte counter, Instruction,
// the flags and mem_ready. They are all forced quiet while rst is low.
module control_fsm #(
  parameter int ADDR_BYTES = 2,
  parameter int OPC_W      = 8
) (
  input logic          clk,
  input logic          rst,
  control_fsm_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_IR = 4'd1, S_DEC = 4'd2, S_IMM = 4'd3, S_OPND = 4'd4,
    S_JUMP = 4'd5, S_ADDR = 4'd6, S_MEM = 4'd7, S_HALT = 4'd8
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_MVA, C_ALU_DR, C_ALU_UN, C_IMM, C_MEMREF, C_JUMP, C_HLT, C_ILL
  } op_class_t;

  localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(8'h00);
  localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(8'h01);
  localparam logic [OPC_W-1:0] OP_LDA  = OPC_W'(8'h02);
  localparam logic [OPC_W-1:0] OP_STA  = OPC_W'(8'h03);
  localparam logic [OPC_W-1:0] OP_MVA  = OPC_W'(8'h04);
  localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(8'h05);
  localparam logic [OPC_W-1:0] OP_JMPZ = OPC_W'(8'h06);
  localparam logic [OPC_W-1:0] OP_JPNZ = OPC_W'(8'h07);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(8'h08);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(8'h09);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(8'h0A);
  localparam logic [OPC_W-1:0] OP_SUBI = OPC_W'(8'h0B);
  localparam logic [OPC_W-1:0] OP_CLA  = OPC_W'(8'h0C);
  localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(8'h0D);
  localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(8'h0E);
  localparam logic [OPC_W-1:0] OP_XOR  = OPC_W'(8'h0F);
  localparam logic [OPC_W-1:0] OP_NOT  = OPC_W'(8'h10);
  localparam logic [OPC_W-1:0] OP_JMPC = OPC_W'(8'h11);
  localparam logic [OPC_W-1:0] OP_JPNC = OPC_W'(8'h12);
  localparam logic [OPC_W-1:0] OP_HLT  = OPC_W'(8'h13);

  localparam logic [1:0] MUX_ACC = 2'b00;
  localparam logic [1:0] MUX_DR  = 2'b01;
  localparam logic [1:0] MUX_MEM = 2'b11;
  localparam logic [1:0] K_INIT  = 2'(ADDR_BYTES - 1);

  state_t                state_r, state_nxt_s;
  logic [1:0]            k_r, k_nxt_s;
  op_class_t             cls_s;
  logic [3:0]            alu_s;
  logic                  jump_taken_s;
  logic [ADDR_BYTES-1:0] k_onehot_s;
  logic [1:0]            mux_s;
  logic                  mem_req_s, we_s, ar_load_s, ar_inc_s, pc_load_s, pc_inc_s;
  logic                  ac_load_s, zc_load_s, ir_load_s, dr_load_s;
  logic                  ab_sel_s, halted_s, illegal_s;
  logic [ADDR_BYTES-1:0] tmp_load_s;

  // Temp address byte k is loaded through a one-hot strobe.
  assign k_onehot_s = ADDR_BYTES'(1) << k_r;

  // Sort the current opcode into the groups that share a control sequence.
  always_comb begin
    cls_s = C_ILL;
    case (bus.Instruction)
      OP_NOP:                                cls_s = C_NOP;
      OP_MVA:                                cls_s = C_MVA;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: cls_s = C_ALU_DR;
      OP_CLA, OP_NOT:                        cls_s = C_ALU_UN;
      OP_LDI, OP_ADDI, OP_SUBI:              cls_s = C_IMM;
      OP_LDA, OP_STA:                        cls_s = C_MEMREF;
      OP_JMP, OP_JMPZ, OP_JPNZ, OP_JMPC, OP_JPNC: cls_s = C_JUMP;
      OP_HLT:                                cls_s = C_HLT;
      default:                               cls_s = C_ILL;
    endcase
  end

  // ALU operation follows the opcode alone; unlisted opcodes select ZERO.
  always_comb begin
    alu_s = 4'd0;
    case (bus.Instruction)
      OP_ADD, OP_ADDI: alu_s = 4'd2;
      OP_SUB, OP_SUBI: alu_s = 4'd3;
      OP_AND:          alu_s = 4'd4;
      OP_OR:           alu_s = 4'd5;
      OP_XOR:          alu_s = 4'd6;
      OP_NOT:          alu_s = 4'd7;
      default:         alu_s = 4'd0;
    endcase
  end

  // Jump condition, using the flags as seen in the jump cycle itself.
  always_comb begin
    jump_taken_s = 1'b0;
    case (bus.Instruction)
      OP_JMP:  jump_taken_s = 1'b1;
      OP_JMPZ: jump_taken_s = bus.flag_z;
      OP_JPNZ: jump_taken_s = ~bus.flag_z;
      OP_JMPC: jump_taken_s = bus.flag_c;
      OP_JPNC: jump_taken_s = ~bus.flag_c;
      default: jump_taken_s = 1'b0;
    endcase
  end

  // State and operand byte counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_FETCH;
      k_r     <= K_INIT;
    end else begin
      state_r <= state_nxt_s;
      k_r     <= k_nxt_s;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_nxt_s = state_r;
    k_nxt_s     = k_r;
    mux_s       = MUX_ACC;
    mem_req_s   = 1'b0;
    we_s        = 1'b0;
    ar_load_s   = 1'b0;
    ar_inc_s    = 1'b0;
    pc_load_s   = 1'b0;
    pc_inc_s    = 1'b0;
    ac_load_s   = 1'b0;
    zc_load_s   = 1'b0;
    ir_load_s   = 1'b0;
    dr_load_s   = 1'b0;
    tmp_load_s  = '0;
    ab_sel_s    = 1'b0;
    halted_s    = 1'b0;
    illegal_s   = 1'b0;
    case (state_r)
      S_FETCH: begin
        ab_sel_s    = 1'b1;
        ar_load_s   = 1'b1;
        state_nxt_s = S_IR;
      end
      S_IR: begin
        mem_req_s = 1'b1;
        mux_s     = MUX_MEM;
        if (bus.mem_ready) begin
          ir_load_s   = 1'b1;
          pc_inc_s    = 1'b1;
          ar_inc_s    = 1'b1;
          state_nxt_s = S_DEC;
        end else begin
          state_nxt_s = S_IR;
        end
      end
      S_DEC: begin
        state_nxt_s = S_FETCH;
        case (cls_s)
          C_NOP: state_nxt_s = S_FETCH;
          C_MVA: begin
            mux_s     = MUX_ACC;
            dr_load_s = 1'b1;
          end
          C_ALU_DR: begin
            mux_s     = MUX_DR;
            ac_load_s = 1'b1;
            zc_load_s = 1'b1;
          end
          C_ALU_UN: begin
            ac_load_s = 1'b1;
            zc_load_s = 1'b1;
          end
          C_IMM:    state_nxt_s = S_IMM;
          C_MEMREF, C_JUMP: begin
            k_nxt_s     = K_INIT;
            state_nxt_s = S_OPND;
          end
          C_HLT:    state_nxt_s = S_HALT;
          default:  illegal_s = 1'b1;
        endcase
      end
      S_IMM: begin
        mem_req_s = 1'b1;
        mux_s     = MUX_MEM;
        if (bus.mem_ready) begin
          ac_load_s   = 1'b1;
          pc_inc_s    = 1'b1;
          ar_inc_s    = 1'b1;
          // LDI leaves the zero flag alone; the arithmetic immediates update it.
          zc_load_s   = (bus.Instruction == OP_ADDI) || (bus.Instruction == OP_SUBI);
          state_nxt_s = S_FETCH;
        end else begin
          state_nxt_s = S_IMM;
        end
      end
      S_OPND: begin
        mem_req_s = 1'b1;
        mux_s     = MUX_MEM;
        if (bus.mem_ready) begin
          tmp_load_s = k_onehot_s;
          pc_inc_s   = 1'b1;
          ar_inc_s   = 1'b1;
          if (k_r == 2'd0) begin
            state_nxt_s = (cls_s == C_JUMP) ? S_JUMP : S_ADDR;
          end else begin
            k_nxt_s = k_r - 2'd1;
          end
        end else begin
          state_nxt_s = S_OPND;
        end
      end
      S_JUMP: begin
        pc_load_s   = jump_taken_s;
        state_nxt_s = S_FETCH;
      end
      S_ADDR: begin
        ab_sel_s    = 1'b0;
        ar_load_s   = 1'b1;
        state_nxt_s = S_MEM;
      end
      S_MEM: begin
        mem_req_s = 1'b1;
        if (bus.Instruction == OP_STA) begin
          mux_s = MUX_ACC;
          we_s  = 1'b1;
        end else begin
          mux_s     = MUX_MEM;
          ac_load_s = bus.mem_ready;
        end
        state_nxt_s = bus.mem_ready ? S_FETCH : S_MEM;
      end
      S_HALT:  halted_s = 1'b1;
      default: state_nxt_s = S_FETCH;
    endcase
  end

  // Drive the interface, holding everything quiet while reset is asserted.
  always_comb begin
    bus.dev_state = state_r;
    if (!rst) begin
      bus.MUX_sel  = 2'b00;  bus.ALU_op  = 4'd0;  bus.mem_req = 1'b0;
      bus.memory_WE = 1'b0;  bus.AR_load = 1'b0;  bus.AR_inc  = 1'b0;
      bus.PC_load  = 1'b0;   bus.PC_inc  = 1'b0;  bus.AC_load = 1'b0;
      bus.ZC_load  = 1'b0;   bus.IR_load = 1'b0;  bus.DR_load = 1'b0;
      bus.TMP_load = '0;     bus.AB_sel  = 1'b0;  bus.halted  = 1'b0;
      bus.illegal  = 1'b0;
    end else begin
      bus.MUX_sel  = mux_s;      bus.ALU_op  = alu_s;     bus.mem_req = mem_req_s;
      bus.memory_WE = we_s;      bus.AR_load = ar_load_s; bus.AR_inc  = ar_inc_s;
      bus.PC_load  = pc_load_s;  bus.PC_inc  = pc_inc_s;  bus.AC_load = ac_load_s;
      bus.ZC_load  = zc_load_s;  bus.IR_load = ir_load_s; bus.DR_load = dr_load_s;
      bus.TMP_load = tmp_load_s; bus.AB_sel  = ab_sel_s;  bus.halted  = halted_s;
      bus.illegal  = illegal_s;
    end
  end
endmodule
